// File: rtl/mbr_sector_gen.sv
// MBR sector generator: streams the 512-byte master boot record (one FAT32 partition entry
// plus 0x55AA signature) followed by its SD data-block CRC16, one byte per shifter request.
module mbr_sector_gen #(
   parameter logic [7:0] PARTTYPE = 8'h0B,
   parameter logic [7:0] BOOTIND  = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] FAT32SA,
   input  logic [31:0] PARTSIZE,
   input  logic        sbreq,
   output logic [7:0]  DATASO,
   output logic [15:0] PTDATAPNTR,
   output logic        bytevalid,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SEND, CRC_HI, CRC_LO} state_t;

   state_t      state, state_nx;
   logic [31:0] sa_q, sa_nx, size_q, size_nx;
   logic [15:0] crc_q, crc_nx, crc_step;
   logic [15:0] ptr_nx, ptr_inc;
   logic [7:0]  data_nx;
   logic        valid_nx, busy_nx, done_nx;

   // CRC16-CCITT (0x1021), MSB first, eight bit-steps unrolled.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // Sector image: everything outside the first partition entry and the signature is zero.
   function automatic logic [7:0] byte_at(input logic [8:0] idx, input logic [31:0] sa,
                                          input logic [31:0] size);
      case (idx)
         9'h1BE:                 byte_at = BOOTIND;
         9'h1BF, 9'h1C3:         byte_at = 8'hFE;
         9'h1C0, 9'h1C1,
         9'h1C4, 9'h1C5:         byte_at = 8'hFF;
         9'h1C2:                 byte_at = PARTTYPE;
         9'h1C6:                 byte_at = sa[7:0];
         9'h1C7:                 byte_at = sa[15:8];
         9'h1C8:                 byte_at = sa[23:16];
         9'h1C9:                 byte_at = sa[31:24];
         9'h1CA:                 byte_at = size[7:0];
         9'h1CB:                 byte_at = size[15:8];
         9'h1CC:                 byte_at = size[23:16];
         9'h1CD:                 byte_at = size[31:24];
         9'h1FE:                 byte_at = 8'h55;
         9'h1FF:                 byte_at = 8'hAA;
         default:                byte_at = 8'h00;
      endcase
   endfunction

   assign crc_step = crc16_byte(crc_q, DATASO);
   assign ptr_inc  = PTDATAPNTR + 16'd1;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_nx = state;
      sa_nx    = sa_q;
      size_nx  = size_q;
      crc_nx   = crc_q;
      ptr_nx   = PTDATAPNTR;
      data_nx  = DATASO;
      valid_nx = bytevalid;
      busy_nx  = busy;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               sa_nx    = FAT32SA;
               size_nx  = PARTSIZE;
               crc_nx   = 16'h0000;
               ptr_nx   = 16'd0;
               data_nx  = byte_at(9'd0, FAT32SA, PARTSIZE);
               valid_nx = 1'b1;
               busy_nx  = 1'b1;
               state_nx = SEND;
            end
         end
         SEND: begin
            if (sbreq) begin
               crc_nx = crc_step;
               if (PTDATAPNTR == 16'd511) begin
                  ptr_nx   = 16'd512;
                  data_nx  = crc_step[15:8];
                  state_nx = CRC_HI;
               end else begin
                  ptr_nx  = ptr_inc;
                  data_nx = byte_at(ptr_inc[8:0], sa_q, size_q);
               end
            end
         end
         CRC_HI: begin
            if (sbreq) begin
               ptr_nx   = 16'd513;
               data_nx  = crc_q[7:0];
               state_nx = CRC_LO;
            end
         end
         CRC_LO: begin
            if (sbreq) begin
               ptr_nx   = 16'd0;
               data_nx  = 8'h00;
               valid_nx = 1'b0;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values together.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sa_q       <= '0;
         size_q     <= '0;
         crc_q      <= '0;
         PTDATAPNTR <= '0;
         DATASO     <= '0;
         bytevalid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         sa_q       <= sa_nx;
         size_q     <= size_nx;
         crc_q      <= crc_nx;
         PTDATAPNTR <= ptr_nx;
         DATASO     <= data_nx;
         bytevalid  <= valid_nx;
         busy       <= busy_nx;
         done       <= done_nx;
      end
   end

endmodule
